// File: rtl/ins_fetch_if.sv
// Bundle of fetch-unit signals: control (start/halt), instruction-memory port and consumer handshake.
interface ins_fetch_if #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned INS_WIDTH  = 9
);
  logic                  start;
  logic [ADDR_WIDTH-1:0] start_addr;
  logic [ADDR_WIDTH-1:0] PC_address;
  logic                  rEn;
  logic [INS_WIDTH-1:0]  instruction;
  logic [INS_WIDTH-1:0]  ir;
  logic [ADDR_WIDTH-1:0] ir_pc;
  logic                  ir_valid;
  logic                  ir_ready;
  logic                  branch_en;
  logic [ADDR_WIDTH-1:0] branch_addr;
  logic                  halted;

  modport master (
    input  start, start_addr, instruction, ir_ready, branch_en, branch_addr,
    output PC_address, rEn, ir, ir_pc, ir_valid, halted
  );

  modport slave (
    output start, start_addr, instruction, ir_ready, branch_en, branch_addr,
    input  PC_address, rEn, ir, ir_pc, ir_valid, halted
  );
endinterface

// File: rtl/ins_fetch.sv
// Instruction fetch unit: one fetch per FETCH/WAIT/DELIVER round trip, with redirect and halt.
module ins_fetch #(
  parameter int unsigned         ADDR_WIDTH = 8,
  parameter int unsigned         INS_WIDTH  = 9,
  parameter logic [INS_WIDTH-1:0] HALT_INS  = INS_WIDTH'(9'h000)
) (
  input  logic          clk,
  input  logic          rst,
  ins_fetch_if.master   bus
);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_FETCH   = 3'd1;
  localparam logic [2:0] ST_WAIT    = 3'd2;
  localparam logic [2:0] ST_DELIVER = 3'd3;
  localparam logic [2:0] ST_HALT    = 3'd4;

  logic [2:0]            state, state_nxt;
  logic [ADDR_WIDTH-1:0] pc, pc_nxt;
  logic [INS_WIDTH-1:0]  ir, ir_nxt;
  logic [ADDR_WIDTH-1:0] ir_pc, ir_pc_nxt;
  logic                  ren_q, ir_valid_q, halted_q;

  // Next-state and datapath updates
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    ir_nxt    = ir;
    ir_pc_nxt = ir_pc;
    case (state)
      ST_IDLE, ST_HALT: begin
        if (bus.start) begin
          pc_nxt    = bus.start_addr;
          state_nxt = ST_FETCH;
        end
      end
      ST_FETCH: state_nxt = ST_WAIT;
      ST_WAIT: begin
        ir_nxt    = bus.instruction;
        ir_pc_nxt = pc;
        pc_nxt    = pc + ADDR_WIDTH'(1);
        state_nxt = ST_DELIVER;
      end
      ST_DELIVER: begin
        // Halt wins over a same-cycle branch; the pc is left untouched.
        if (bus.ir_ready) begin
          if (ir == HALT_INS) begin
            state_nxt = ST_HALT;
          end else begin
            if (bus.branch_en) pc_nxt = bus.branch_addr;
            state_nxt = ST_FETCH;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State, datapath and state-decoded outputs registered together
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      pc         <= '0;
      ir         <= '0;
      ir_pc      <= '0;
      ren_q      <= 1'b0;
      ir_valid_q <= 1'b0;
      halted_q   <= 1'b0;
    end else begin
      state      <= state_nxt;
      pc         <= pc_nxt;
      ir         <= ir_nxt;
      ir_pc      <= ir_pc_nxt;
      ren_q      <= (state_nxt == ST_FETCH);
      ir_valid_q <= (state_nxt == ST_DELIVER);
      halted_q   <= (state_nxt == ST_HALT);
    end
  end

  assign bus.PC_address = pc;
  assign bus.rEn        = ren_q;
  assign bus.ir         = ir;
  assign bus.ir_pc      = ir_pc;
  assign bus.ir_valid   = ir_valid_q;
  assign bus.halted     = halted_q;

endmodule
